// File: rtl/pwm_gen_if.sv
// Control and waveform signals between the PWM register fields and the PWM generator.
// The master drives the configuration; the slave (pwm_gen) returns the waveform and status.
interface pwm_gen_if #(
   parameter int CNT_W = 32,
   parameter int DIV_W = 5
);
   logic             en;
   logic             restart;
   logic [DIV_W-1:0] div_cfg;
   logic [CNT_W-1:0] duty_cfg;
   logic             pwm_out;
   logic             period_tick;
   logic             running;

   modport master (
      output en, restart, div_cfg, duty_cfg,
      input  pwm_out, period_tick, running
   );

   modport slave (
      input  en, restart, div_cfg, duty_cfg,
      output pwm_out, period_tick, running
   );
endinterface

// File: rtl/pwm_gen.sv
// Double-buffered PWM generator, period 2^div cycles; pwm_out lags cnt by one cycle.
// No backpressure: cfg is sampled every cycle and only takes effect at a period boundary or restart.
module pwm_gen #(
   parameter int CNT_W = 32,
   parameter int DIV_W = 5
) (
   input  logic     S_AXI_ACLK,
   input  logic     S_AXI_ARESETN,
   pwm_gen_if.slave pwm
);
   typedef enum logic {IDLE, RUN} state_t;

   localparam logic [CNT_W:0]   WIDE_ONE = {{CNT_W{1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] duty_act;
   logic [DIV_W-1:0] div_act;
   logic             pwm_q;
   logic             tick_q;

   // Terminal count carries one extra bit so the largest period cannot wrap to zero.
   logic [CNT_W:0]   last_cnt;
   logic             at_last;
   logic             duty_hit;

   assign last_cnt = (WIDE_ONE << div_act) - WIDE_ONE;
   assign at_last  = ({1'b0, cnt} == last_cnt);
   assign duty_hit = (cnt < duty_act);

   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         state    <= IDLE;
         cnt      <= '0;
         div_act  <= '0;
         duty_act <= '0;
         pwm_q    <= 1'b0;
         tick_q   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               cnt      <= '0;
               pwm_q    <= 1'b0;
               tick_q   <= 1'b0;
               div_act  <= pwm.div_cfg;
               duty_act <= pwm.duty_cfg;
               if (pwm.en) state <= RUN;
            end
            RUN: begin
               if (!pwm.en) begin
                  state    <= IDLE;
                  cnt      <= '0;
                  pwm_q    <= 1'b0;
                  tick_q   <= 1'b0;
                  div_act  <= pwm.div_cfg;
                  duty_act <= pwm.duty_cfg;
               end else if (pwm.restart) begin
                  cnt      <= '0;
                  pwm_q    <= 1'b0;
                  tick_q   <= 1'b0;
                  div_act  <= pwm.div_cfg;
                  duty_act <= pwm.duty_cfg;
               end else begin
                  pwm_q <= duty_hit;
                  if (at_last) begin
                     cnt      <= '0;
                     tick_q   <= 1'b1;
                     div_act  <= pwm.div_cfg;
                     duty_act <= pwm.duty_cfg;
                  end else begin
                     cnt    <= cnt + CNT_ONE;
                     tick_q <= 1'b0;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign pwm.pwm_out     = pwm_q;
   assign pwm.period_tick = tick_q;
   assign pwm.running     = (state == RUN);
endmodule

// File: doc/pwm_gen.md
# pwm_gen

Programmable PWM generator sitting directly downstream of the AXI-Lite register file in `neuromorphic_asic_bridge_top`. It consumes the PWM divider and duty-cycle registers and produces the PWM waveform. The debug register routes that waveform to the ASIC clock/stimulus path or the LEDs. Period and duty are double-buffered, so register writes never produce a truncated or glitched period.

## Interface
Parameters:
- `CNT_W`, 32: width of the period counter and of the duty compare.
- `DIV_W`, 5: width of the divider exponent. Period is 2^div cycles, so 2^(2^DIV_W − 1) must fit in `CNT_W`+1 bits.

Ports:
- `S_AXI_ACLK` in 1: single clock for the whole block.
- `S_AXI_ARESETN` in 1: reset, asynchronous and active-low.
- `en` in 1: run enable (debug register bit), level-sensitive.
- `restart` in 1: one-cycle pulse that aborts the current period and reloads the config.
- `div_cfg` in `DIV_W`: PWM DIV register value.
- `duty_cfg` in `CNT_W`: PWM duty register value, in counts.
- `pwm_out` out 1: registered PWM output.
- `period_tick` out 1: one-cycle pulse on the last cycle of each period.
- `running` out 1: high while in RUN.

## Operation
- FSM has two states:
  - IDLE: entered on reset.
  - RUN.
- IDLE:
  - `cnt` = 0, `pwm_out` = 0, `period_tick` = 0.
  - Shadow registers `div_act` and `duty_act` load from `div_cfg` and `duty_cfg` every cycle.
  - `en` = 1 at an edge: go to RUN with `cnt` = 0 and the shadows loaded from the current cfg.
- RUN:
  - Period P = 1 << `div_act`. Compute the terminal count `cnt` == P−1 without overflow; P = 2^31 is legal for `CNT_W` = 32.
  - At each edge: if `cnt` == P−1, then `cnt` ← 0, reload both shadows from cfg, and `period_tick` ← 1. Otherwise `cnt` ← `cnt`+1 and `period_tick` ← 0.
  - `pwm_out` ← (`cnt` < `duty_act`), an unsigned compare on the pre-edge values.
  - `duty_act` = 0 gives a constant low output.
  - `duty_act` ≥ P gives a constant high output (100 %); no saturation logic is needed beyond the compare.
  - `en` = 0 at an edge: go to IDLE, `pwm_out` ← 0, `cnt` ← 0. There is no period completion.
- `restart` = 1 in RUN: `cnt` ← 0, reload the shadows, `period_tick` ← 0, `pwm_out` ← 0 for that edge.
- `restart` in IDLE is ignored.
- Simultaneous events, in priority order: reset > `en` = 0 > `restart` > terminal count.
- cfg changes mid-period take effect only at the next boundary or on `restart`.
- `div_act` = 0 (P = 1):
  - `cnt` stays 0 and `period_tick` is high every RUN cycle.
  - `pwm_out` is constant, set by duty ≥ 1.
- `running` = (state == RUN), combinational from the state register.

## Timing
- Reset values: state IDLE, `cnt` 0, shadows 0, `pwm_out` 0, `period_tick` 0, `running` 0.
- Reset asserted mid-period forces all of the above asynchronously. On release the block restarts from IDLE.
- Edge E0 samples `en` = 1. `running` is high after E0.
- `pwm_out` first reflects the period at E1, so there is 1 cycle of latency from `cnt` to `pwm_out`.
- Period is exactly P cycles.
- Steady-state high time is exactly min(duty, P) cycles per period.
- `period_tick` is high during the cycle after `cnt` == P−1 was sampled, aligned with the final `pwm_out` cycle of that period.
- Edge sampling `en` = 0: `pwm_out` is 0 after that edge, so there is one cycle of latency.
- There is no handshake on cfg inputs: they are register outputs, stable and sampled every cycle.

## Test plan
- Reset / idle: hold `S_AXI_ARESETN` = 0 for 10 cycles, then release with `en` = 0 → `pwm_out`, `period_tick` and `running` are all 0 for 100 cycles.
- Basic PWM: `div_cfg` = 2, `duty_cfg` = 1, `en` = 1 → `pwm_out` repeats 1,0,0,0 starting 2 edges after enable, and `period_tick` fires every 4 cycles.
- Sweep:
  - For div = 0..7, step duty from 0 to 2^div.
  - Required: high count per period = duty.
  - Required: duty 0 → always 0, duty = 2^div → always 1.
  - Also check duty = 1000 at div = 3 → always 1.
- Double-buffering: with div = 3 and duty = 2, change duty to 6 at `cnt` = 1 → the current period stays 2 high; the next period is 6 high.
- Control events:
  - `en` low at `cnt` = 5 with div = 4 → `pwm_out` is 0 the next cycle.
  - Re-enable → a fresh period from `cnt` = 0.
  - `restart` together with a terminal count → `cnt` goes to 0 and no `period_tick` is produced.
- Reset mid-operation with div = 26, duty = 0x100 → all outputs go to 0 immediately, with no glitch after release while `en` = 0.
